// File: rtl/fp_unpack.sv
// fp_unpack: operand front end for the FP add/sub datapath.
// Splits a packed IEEE-754 word into sign, unbiased signed exponent,
// significand and a one-hot class. Subnormals are normalized iteratively,
// at most STEP bit positions per cycle, behind a valid/ready handshake with
// a single-entry output register.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_data = {sign, exponent, fraction}
//   out_valid / out_ready output handshake
//   negOut               sign bit
//   expOut               unbiased exponent, signed, NEXP+2 bits
//   sigOut               significand; finite nonzero: sigOut[NSIG]=1 and
//                        value = sigOut * 2^(expOut-NSIG)
//   cls                  one-hot {snan, qnan, inf, zero, subnormal, normal}
module fp_unpack #(
  parameter int NEXP = 8,
  parameter int NSIG = 23,
  parameter int STEP = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   negOut,
  output logic signed [NEXP+1:0] expOut,
  output logic [NSIG:0]          sigOut,
  output logic [5:0]             cls
);

  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam int EMIN = 1 - BIAS;
  localparam int EMAX = BIAS;
  localparam int EW   = NEXP + 2;
  localparam int SW   = NSIG + 1;
  localparam int LW   = $clog2(STEP + 1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t state, stateNext;

  logic                 accept;
  logic                 sgn;
  logic [NEXP-1:0]      expField;
  logic [NSIG-1:0]      frac;
  logic                 eOnes, eZero, fZero, isSub;
  logic signed [EW-1:0] expLoad;
  logic [SW-1:0]        sigLoad;
  logic [5:0]           clsLoad;
  logic [LW-1:0]        lz;
  logic                 lzFound;
  logic                 normDone;

  assign sgn      = in_data[NEXP+NSIG];
  assign expField = in_data[NSIG +: NEXP];
  assign frac     = in_data[NSIG-1:0];
  assign eOnes    = &expField;
  assign eZero    = ~|expField;
  assign fZero    = ~|frac;
  assign isSub    = eZero & ~fZero;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  // Classify and decode the incoming operand.
  always_comb begin
    expLoad = EW'(EMIN);
    sigLoad = '0;
    clsLoad = 6'b000100;
    if (eOnes) begin
      expLoad = EW'(EMAX + 1);
      sigLoad = {1'b0, frac};
      if (fZero)
        clsLoad = 6'b001000;
      else if (frac[NSIG-1])
        clsLoad = 6'b010000;
      else
        clsLoad = 6'b100000;
    end else if (!eZero) begin
      expLoad = $signed({2'b00, expField}) - EW'(BIAS);
      sigLoad = {1'b1, frac};
      clsLoad = 6'b000001;
    end else if (!fZero) begin
      expLoad = EW'(EMIN);
      sigLoad = {1'b0, frac};
      clsLoad = 6'b000010;
    end
  end

  // Leading zeros within the top STEP bits of the working significand.
  // An all-zero window yields lz == STEP, so the same shift-by-lz update
  // covers both the full-step and the final partial-step cases.
  always_comb begin
    lz      = '0;
    lzFound = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (!lzFound && !sigOut[SW-1-i])
        lz = lz + LW'(1);
      else
        lzFound = 1'b1;
    end
  end

  assign normDone = (lz != LW'(STEP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = isSub ? NORM : DONE;
      NORM: if (normDone) stateNext = DONE;
      DONE: begin
        if (accept)
          stateNext = isSub ? NORM : DONE;
        else if (out_ready)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output registers double as the normalization working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negOut <= 1'b0;
      expOut <= '0;
      sigOut <= '0;
      cls    <= '0;
    end else if (accept) begin
      negOut <= sgn;
      expOut <= expLoad;
      sigOut <= sigLoad;
      cls    <= clsLoad;
    end else if (state == NORM) begin
      sigOut <= sigOut << lz;
      expOut <= expOut - EW'(lz);
    end
  end

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack (binary32 configuration, STEP=4):
// directed cases plus randomized operands against a behavioural model.
module tb_fp_unpack;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic               negOut;
  logic signed [9:0]  expOut;
  logic [23:0]        sigOut;
  logic [5:0]         cls;

  int vectors = 0;
  int miscompares = 0;

  fp_unpack #(.NEXP(8), .NSIG(23), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .negOut    (negOut),
    .expOut    (expOut),
    .sigOut    (sigOut),
    .cls       (cls)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: IEEE-754 binary32 decode with arithmetic normalization.
  task automatic model(input logic [31:0] w, output bit neg, output int e,
                       output logic [23:0] sig, output logic [5:0] c, output int lat);
    int ef;
    int f;
    int v;
    int k;
    ef  = int'(w[30:23]);
    f   = int'(w[22:0]);
    neg = w[31];
    lat = 1;
    if (ef == 255) begin
      e   = 128;
      sig = 24'(f);
      if (f == 0)                  c = 6'b001000;
      else if (f >= (1 << 22))     c = 6'b010000;
      else                         c = 6'b100000;
    end else if (ef == 0 && f == 0) begin
      e = -126; sig = '0; c = 6'b000100;
    end else if (ef != 0) begin
      e = ef - 127; sig = 24'(f + (1 << 23)); c = 6'b000001;
    end else begin
      v = f; k = 0;
      while (v < (1 << 23)) begin
        v = v * 2;
        k++;
      end
      e   = -126 - k;
      sig = 24'(v);
      c   = 6'b000010;
      lat = 2 + k / 4;
    end
  endtask

  task automatic checkOutputs(input string tag, input bit neg, input int e,
                              input logic [23:0] sig, input logic [5:0] c);
    checkEq({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkEq({tag, ".neg"}, 64'(negOut), 64'(neg));
    checkEq({tag, ".exp"}, 64'(expOut), 64'(10'(e)));
    checkEq({tag, ".sig"}, 64'(sigOut), 64'(sig));
    checkEq({tag, ".cls"}, 64'(cls), 64'(c));
  endtask

  // Present one operand, measure latency, check result, hold for 'hold'
  // cycles with out_ready low, then optionally drain it.
  task automatic applyOp(input logic [31:0] w, input int hold, input bit drain);
    bit eNeg;
    int eExp;
    logic [23:0] eSig;
    logic [5:0] eCls;
    int eLat;
    int lat;
    model(w, eNeg, eExp, eSig, eCls, eLat);
    @(negedge clk);
    in_valid = 1'b1; in_data = w; out_ready = 1'b0;
    checkEq("inReadyIdle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      checkEq("inReadyNorm", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    checkEq("latency", 64'(lat), 64'(eLat));
    checkOutputs("result", eNeg, eExp, eSig, eCls);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkEq("holdReady", 64'(in_ready), 64'd0);
      checkOutputs("hold", eNeg, eExp, eSig, eCls);
    end
    if (drain) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      checkEq("drainValid", 64'(out_valid), 64'd0);
      checkEq("drainReady", 64'(in_ready), 64'd1);
      out_ready = 1'b0;
    end
  endtask

  function automatic logic [31:0] randOperand();
    logic [31:0] w;
    logic [22:0] f;
    int sel;
    sel = $urandom_range(0, 5);
    w = $urandom;
    f = w[22:0];
    case (sel)
      1: begin
        f = f >> $urandom_range(0, 22);
        if (f == '0) f = 23'd1;
        w = {w[31], 8'h00, f};
      end
      2: w = {w[31], 31'd0};
      3: w = {w[31], 8'hFF, ($urandom_range(0, 3) == 0) ? 23'd0 : f};
      4, 5: if (w[30:23] == 8'h00 || w[30:23] == 8'hFF) w[30:23] = 8'h80;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #17;
    checkEq("rstValid", 64'(out_valid), 64'd0);
    checkEq("rstNeg", 64'(negOut), 64'd0);
    checkEq("rstExp", 64'(expOut), 64'd0);
    checkEq("rstSig", 64'(sigOut), 64'd0);
    checkEq("rstCls", 64'(cls), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    applyOp(32'h3F800000, 0, 1'b1);
    applyOp(32'h00000001, 0, 1'b1);
    applyOp(32'h80400000, 1, 1'b1);
    applyOp(32'h7F800001, 0, 1'b1);
    applyOp(32'h7FC00000, 0, 1'b1);
    applyOp(32'hFF800000, 0, 1'b1);
    applyOp(32'h00000010, 0, 1'b1);

    // Zero held three cycles, then a back-to-back stream.
    applyOp(32'h80000000, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h40000000; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutputs("stream0", 1'b0, 1, 24'h800000, 6'b000001);
    in_data = 32'h40400000;
    @(posedge clk); #1;
    checkOutputs("stream1", 1'b0, 1, 24'hC00000, 6'b000001);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkEq("streamEnd", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Reset in the third NORM cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h00000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checkEq("midRstValid", 64'(out_valid), 64'd0);
    checkEq("midRstExp", 64'(expOut), 64'd0);
    checkEq("midRstSig", 64'(sigOut), 64'd0);
    checkEq("midRstCls", 64'(cls), 64'd0);
    checkEq("midRstNeg", 64'(negOut), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checkEq("postRstValid", 64'(out_valid), 64'd0);
      checkEq("postRstReady", 64'(in_ready), 64'd1);
    end

    for (int n = 0; n < 250; n++)
      applyOp(randOperand(), $urandom_range(0, 2), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
